// File: rtl/memory_initiator_pkg.sv
// ============================================================================
// Module   : memory_initiator_pkg
// Purpose  : Shared defaults, FSM encodings and opcode type for memory_initiator
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package memory_initiator_pkg;

    localparam int c_addr_w_def     = 9;
    localparam int c_data_w_def     = 32;
    localparam int c_fifo_depth_def = 2;

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_setup   = 3'd1;
    localparam logic [2:0] c_st_access  = 3'd2;
    localparam logic [2:0] c_st_capture = 3'd3;
    localparam logic [2:0] c_st_done    = 3'd4;

    typedef enum logic {
        c_op_read  = 1'b0,
        c_op_write = 1'b1
    } op_e;

endpackage

`default_nettype wire

// File: rtl/memory_initiator_req_fifo.sv
// ============================================================================
// Module   : memory_initiator_req_fifo
// Purpose  : Small synchronous request FIFO of {write, addr, wdata} entries
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_initiator_req_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 42
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    // A push is refused while full even if the same edge pops.
    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

`default_nettype wire

// File: rtl/memory_initiator.sv
// ============================================================================
// Module   : memory_initiator
// Purpose  : Sequences buffered CPU requests into 512x32 RAM read/write strobes
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_initiator
    import memory_initiator_pkg::*;
#(
    parameter int ADDR_W     = c_addr_w_def,
    parameter int DATA_W     = c_data_w_def,
    parameter int FIFO_DEPTH = c_fifo_depth_def
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_read,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int ENTRY_W = 1 + ADDR_W + DATA_W;

    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    logic [ENTRY_W-1:0] fifo_head;
    logic               head_write;
    logic [ADDR_W-1:0]  head_addr;
    logic [DATA_W-1:0]  head_wdata;

    logic [2:0]         state_q, state_d;
    op_e                op_q, op_d;
    logic [ADDR_W-1:0]  ram_address_q, ram_address_d;
    logic [DATA_W-1:0]  ram_wdata_q, ram_wdata_d;
    logic               ram_read_q, ram_read_d;
    logic               ram_write_q, ram_write_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_write_q, rsp_write_d;
    logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;

    memory_initiator_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_req_fifo (
        .clk   (clk),
        .clr_n (clr_n),
        .push  (req_valid),
        .pop   (fifo_pop),
        .din   ({req_write, req_addr, req_wdata}),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    assign head_write = fifo_head[ENTRY_W-1];
    assign head_addr  = fifo_head[DATA_W +: ADDR_W];
    assign head_wdata = fifo_head[DATA_W-1:0];

    // Strobe and response flops are loaded one state ahead so every RAM-side
    // and response output comes straight from a register.
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        ram_address_d = ram_address_q;
        ram_wdata_d   = ram_wdata_q;
        ram_read_d    = 1'b0;
        ram_write_d   = 1'b0;
        rsp_valid_d   = 1'b0;
        rsp_write_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        fifo_pop      = 1'b0;
        unique case (state_q)
            c_st_idle, c_st_done: begin
                if (!fifo_empty) begin
                    fifo_pop      = 1'b1;
                    op_d          = op_e'(head_write);
                    ram_address_d = head_addr;
                    ram_wdata_d   = head_wdata;
                    state_d       = c_st_setup;
                end else begin
                    state_d = c_st_idle;
                end
            end
            c_st_setup: begin
                ram_read_d  = (op_q == c_op_read);
                ram_write_d = (op_q == c_op_write);
                state_d     = c_st_access;
            end
            c_st_access: begin
                if (op_q == c_op_write) begin
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b1;
                    state_d     = c_st_done;
                end else begin
                    state_d = c_st_capture;
                end
            end
            c_st_capture: begin
                // Only window in which the RAM output is guaranteed valid.
                rsp_rdata_d = ram_rdata;
                rsp_valid_d = 1'b1;
                state_d     = c_st_done;
            end
            default: begin
                state_d = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q       <= c_st_idle;
            op_q          <= c_op_read;
            ram_address_q <= '0;
            ram_wdata_q   <= '0;
            ram_read_q    <= 1'b0;
            ram_write_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_write_q   <= 1'b0;
            rsp_rdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            ram_address_q <= ram_address_d;
            ram_wdata_q   <= ram_wdata_d;
            ram_read_q    <= ram_read_d;
            ram_write_q   <= ram_write_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_write_q   <= rsp_write_d;
            rsp_rdata_q   <= rsp_rdata_d;
        end
    end

    assign req_ready   = !fifo_full;
    assign busy        = (state_q != c_st_idle) || !fifo_empty;
    assign ram_address = ram_address_q;
    assign ram_wdata   = ram_wdata_q;
    assign ram_read    = ram_read_q;
    assign ram_write   = ram_write_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_write   = rsp_write_q;
    assign rsp_rdata   = rsp_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_memory_initiator.sv
// ============================================================================
// Module   : tb_memory_initiator
// Purpose  : Directed bench pairing memory_initiator with a 512x32 RAM model
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_memory_initiator;

    localparam logic [31:0] c_junk = 32'h5A5A_F00F;

    typedef struct {
        logic        wr;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        wr;
        logic [31:0] rdata;
    } rsp_t;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [8:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready;
    logic        rsp_valid;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic        busy;
    logic [8:0]  ram_address;
    logic        ram_read;
    logic        ram_write;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    int   n_checks;
    int   n_errors;
    rsp_t exp_q[$];
    vec_t vecs [12];

    logic [31:0] ram_mem [512];
    bit          loaded;
    bit          prev_strobe;

    always #5 clk = ~clk;

    memory_initiator dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_write   (rsp_write),
        .rsp_rdata   (rsp_rdata),
        .busy        (busy),
        .ram_address (ram_address),
        .ram_read    (ram_read),
        .ram_write   (ram_write),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    // RAM model: word i preloads to 0xC0DE0000|i; output is junk unless read.
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 512; i++) ram_mem[i] <= 32'hC0DE_0000 | 32'(i);
            ram_mem[5] <= 32'h1234_5678;
            loaded     <= 1'b1;
        end else if (ram_write) begin
            ram_mem[ram_address] <= ram_wdata;
        end
        ram_rdata <= ram_read ? ram_mem[ram_address] : c_junk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (clr_n) begin
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    rsp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_write", 32'(rsp_write), 32'(e.wr));
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                end
            end
            if (ram_read || ram_write) begin
                chk("strobe_single", {30'd0, ram_read & ram_write, prev_strobe | !busy}, 32'd0);
            end
            prev_strobe = ram_read | ram_write;
        end else begin
            prev_strobe = 1'b0;
        end
    end

    // Call just after a posedge; returns #1 after the accepting edge.
    task automatic drive_req(input logic w, input logic [8:0] a, input logic [31:0] d,
                             output int waited);
        int n = 0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        waited = n;
        if (!req_ready) chk("push_timeout", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0) && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_pending_rsp", 32'(exp_q.size()), 32'd0);
        chk("idle_strobes_known", {29'd0, ram_read, ram_write, $isunknown(rsp_rdata)}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] rv, rr;
        logic [3:0] wv, ww;
        logic [31:0] wd;
        int w;

        vecs[0]  = '{1'b0, 9'h005, 32'h0,         32'h1234_5678};
        vecs[1]  = '{1'b1, 9'h0A0, 32'hDEAD_BEEF, 32'h1234_5678};
        vecs[2]  = '{1'b0, 9'h0A0, 32'h0,         32'hDEAD_BEEF};
        vecs[3]  = '{1'b0, 9'h1FF, 32'h0,         32'hC0DE_01FF};
        vecs[4]  = '{1'b1, 9'h1FF, 32'hA5A5_5A5A, 32'hC0DE_01FF};
        vecs[5]  = '{1'b0, 9'h000, 32'h0,         32'hC0DE_0000};
        vecs[6]  = '{1'b0, 9'h1FF, 32'h0,         32'hA5A5_5A5A};
        vecs[7]  = '{1'b1, 9'h000, 32'h0BAD_F00D, 32'hA5A5_5A5A};
        vecs[8]  = '{1'b0, 9'h1FF, 32'h0,         32'hA5A5_5A5A};
        vecs[9]  = '{1'b0, 9'h000, 32'h0,         32'h0BAD_F00D};
        vecs[10] = '{1'b0, 9'h100, 32'h0,         32'hC0DE_0100};
        vecs[11] = '{1'b0, 9'h0C3, 32'h0,         32'h0000_C3C3};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp", {30'd0, rsp_valid, rsp_write}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_ram_strobes", {30'd0, ram_read, ram_write}, 32'd0);
        chk("rst_ram_address", 32'(ram_address), 32'd0);
        chk("rst_ram_wdata", ram_wdata, 32'd0);
        clr_n = 1'b1;

        // Read latency: rsp_valid in the cycle after E4
        wait_idle();
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 9'h005; req_wdata = '0;
        exp_q.push_back('{1'b0, 32'h1234_5678});
        @(negedge clk);
        chk("rd_lat_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            rv[c] = rsp_valid;
            rr[c] = ram_read;
        end
        chk("rd_lat_rsp_valid", 32'(rv), 32'b10000);
        chk("rd_lat_ram_read", 32'(rr), 32'b00100);
        chk("rd_lat_address", 32'(ram_address), 32'h005);

        // Write latency: ack in the cycle after E3
        wait_idle();
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 9'h0C3; req_wdata = 32'h0000_C3C3;
        exp_q.push_back('{1'b1, 32'h1234_5678});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wd = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            wv[c] = rsp_valid;
            ww[c] = ram_write;
            if (c == 2) wd = ram_wdata;
        end
        chk("wr_lat_rsp_valid", 32'(wv), 32'b1000);
        chk("wr_lat_ram_write", 32'(ww), 32'b0100);
        chk("wr_lat_wdata", wd, 32'h0000_C3C3);

        // Back-to-back table of reads/writes, incl. address 0x1FF/0x000/0x100
        wait_idle();
        @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            exp_q.push_back('{vecs[i].wr, vecs[i].exp_rdata});
            drive_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, w);
        end

        // FIFO full: fourth request waits exactly three cycles
        wait_idle();
        @(posedge clk);
        #1;
        exp_q.push_back('{1'b0, 32'h1234_5678});
        drive_req(1'b0, 9'h005, 32'h0, w);
        chk("full_wait_a", 32'(w), 32'd0);
        exp_q.push_back('{1'b1, 32'h1234_5678});
        drive_req(1'b1, 9'h0A0, 32'h1122_3344, w);
        chk("full_wait_b", 32'(w), 32'd0);
        exp_q.push_back('{1'b0, 32'h1122_3344});
        drive_req(1'b0, 9'h0A0, 32'h0, w);
        chk("full_wait_c", 32'(w), 32'd0);
        exp_q.push_back('{1'b0, 32'hC0DE_0100});
        drive_req(1'b0, 9'h100, 32'h0, w);
        chk("full_wait_d", 32'(w), 32'd3);

        // Reset during ACCESS of a read with a write still buffered
        wait_idle();
        @(posedge clk);
        #1;
        drive_req(1'b0, 9'h1FF, 32'h0, w);
        drive_req(1'b1, 9'h0A0, 32'hFFFF_0000, w);
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_pre_read", 32'(ram_read), 32'd1);
        #2;
        clr_n = 1'b0;
        #1;
        chk("mid_rst_strobes", {30'd0, ram_read, ram_write}, 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        @(negedge clk);
        clr_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        exp_q.push_back('{1'b0, 32'h1122_3344});
        drive_req(1'b0, 9'h0A0, 32'h0, w);
        exp_q.push_back('{1'b0, 32'hA5A5_5A5A});
        drive_req(1'b0, 9'h1FF, 32'h0, w);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
